// File: rtl/counter_pkg.sv
// Shared definitions for the counter controller and counter-side blocks:
// command opcodes, arbiter FSM states and small opcode classifiers.
package counter_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_WSET = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  // Commands whose ARG is a repeat count rather than a data value.
  function automatic logic is_repeat(input logic [2:0] op);
    return (op == OP_INC) || (op == OP_DEC) || is_shift(op);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the requester not served last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    grant = (req0 && req1) ? ~last : req1;
  end

endmodule

// File: rtl/counter_arbiter.sv
// Arbitrates counter commands from two requesters and sequences the counter
// control strobes for the winner, repeating INC/DEC/SHL/SHR ARG times.
module counter_arbiter
  import counter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         C,
  input  logic         R,
  input  logic         REQ0,
  input  logic         REQ1,
  input  logic [2:0]   OP0,
  input  logic [2:0]   OP1,
  input  logic [N-1:0] ARG0,
  input  logic [N-1:0] ARG1,
  input  logic         FILL0,
  input  logic         FILL1,
  output logic         ACK0,
  output logic         ACK1,
  output logic         BUSY,
  output logic         L,
  output logic         INC,
  output logic         DEC,
  output logic         SHL,
  output logic         SHR,
  output logic         CLR,
  output logic [N-1:0] D,
  output logic [N-1:0] W,
  output logic [1:0]   dbg_state
);

  // Handshake: a requester raises REQx with OP/ARG/FILL and holds them
  // stable until its one-cycle ACKx; REQ still high in the IDLE cycle after
  // ACK is taken as a fresh command.

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state;
  logic [2:0]   op_q;
  logic [N-1:0] arg_q;
  logic         fill_q;
  logic         gnt_q;
  logic         last_q;
  logic [N-1:0] cnt_q;
  logic [N-1:0] w_q;

  logic         grant;
  logic         valid;
  logic [2:0]   sel_op;
  logic [N-1:0] sel_arg;
  logic         sel_fill;

  rr_arb2 u_rr (
    .req0  (REQ0),
    .req1  (REQ1),
    .last  (last_q),
    .grant (grant),
    .valid (valid)
  );

  always_comb begin
    sel_op   = grant ? OP1   : OP0;
    sel_arg  = grant ? ARG1  : ARG0;
    sel_fill = grant ? FILL1 : FILL0;
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state  <= ST_IDLE;
      op_q   <= OP_NOP;
      arg_q  <= '0;
      fill_q <= 1'b0;
      gnt_q  <= 1'b0;
      last_q <= 1'b1;
      cnt_q  <= '0;
      w_q    <= '1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid) begin
            op_q   <= sel_op;
            arg_q  <= sel_arg;
            fill_q <= sel_fill;
            gnt_q  <= grant;
            last_q <= grant;
            if (sel_op == OP_NOP || sel_op == OP_WSET) begin
              state <= ST_DONE;
              cnt_q <= '0;
              if (sel_op == OP_WSET) w_q <= sel_arg;
            end else begin
              state <= ST_RUN;
              // A repeat count of zero still performs one step.
              cnt_q <= (is_repeat(sel_op) && sel_arg != '0) ? sel_arg : ONE;
            end
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - ONE;
          if (cnt_q == ONE) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Every output below depends only on registered state.
  logic run;
  always_comb begin
    run  = (state == ST_RUN);
    L    = run && (op_q == OP_LOAD);
    INC  = run && (op_q == OP_INC);
    DEC  = run && (op_q == OP_DEC);
    SHL  = run && (op_q == OP_SHL);
    SHR  = run && (op_q == OP_SHR);
    CLR  = run && (op_q == OP_CLR);
    ACK0 = (state == ST_DONE) && !gnt_q;
    ACK1 = (state == ST_DONE) && gnt_q;
    BUSY = (state != ST_IDLE);
    D    = '0;
    if (run) begin
      if (op_q == OP_LOAD)    D = arg_q;
      else if (is_shift(op_q)) D = {N{fill_q}};
    end
  end

  assign W         = w_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: hand-computed strobe counts, ACK
// latencies, W register behaviour, reset abort and round-robin order.
module tb_counter_arbiter;
  import counter_pkg::*;

  localparam int N = 4;

  logic         C = 1'b0;
  logic         R;
  logic         REQ0, REQ1;
  logic [2:0]   OP0, OP1;
  logic [N-1:0] ARG0, ARG1;
  logic         FILL0, FILL1;
  logic         ACK0, ACK1, BUSY;
  logic         L, INC, DEC, SHL, SHR, CLR;
  logic [N-1:0] D, W;
  logic [1:0]   dbg_state;

  int compared   = 0;
  int mismatched = 0;
  logic [0:0] exp_q[$];

  counter_arbiter #(.N(N)) dut (
    .C(C), .R(R), .REQ0(REQ0), .REQ1(REQ1), .OP0(OP0), .OP1(OP1),
    .ARG0(ARG0), .ARG1(ARG1), .FILL0(FILL0), .FILL1(FILL1),
    .ACK0(ACK0), .ACK1(ACK1), .BUSY(BUSY),
    .L(L), .INC(INC), .DEC(DEC), .SHL(SHL), .SHR(SHR), .CLR(CLR),
    .D(D), .W(W), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 C = ~C;

  task automatic tick;
    @(posedge C);
    #1;
  endtask

  task automatic do_reset;
    R = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
    tick; tick;
    R = 1'b0;
    tick;
  endtask

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {L, INC, DEC, SHL, SHR, CLR};
  endfunction

  // Drivers
  task automatic set_req(input int who, input logic [2:0] op, input logic [N-1:0] arg,
                         input logic fill);
    if (who == 0) begin
      OP0 = op; ARG0 = arg; FILL0 = fill; REQ0 = 1'b1;
    end else begin
      OP1 = op; ARG1 = arg; FILL1 = fill; REQ1 = 1'b1;
    end
  endtask

  task automatic drop(input int who);
    if (who == 0) REQ0 = 1'b0;
    else          REQ1 = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input int who, input logic [2:0] op,
                        input logic [N-1:0] arg, input logic fill,
                        input logic [5:0] exp_sv, input int exp_n,
                        input logic [N-1:0] exp_d);
    int   cyc, ack_at, n_str, n_bad, busy_n;
    logic mine, other;
    set_req(who, op, arg, fill);
    cyc = 0; ack_at = -1; n_str = 0; n_bad = 0; busy_n = 0;
    while (ack_at < 0 && cyc < 40) begin
      tick;
      cyc++;
      if (BUSY) busy_n++;
      mine  = (who == 0) ? ACK0 : ACK1;
      other = (who == 0) ? ACK1 : ACK0;
      if (exp_sv != 6'b0 && strobes() == exp_sv) begin
        n_str++;
        if (D !== exp_d) n_bad++;
      end else if (strobes() != 6'b0) begin
        n_bad++;
      end
      if (other) n_bad++;
      if (mine) ack_at = cyc;
    end
    drop(who);
    chk({tag, "_ack_cycle"}, ack_at, exp_n + 1);
    chk({tag, "_strobe_cycles"}, n_str, exp_n);
    chk({tag, "_bad_cycles"}, n_bad, 0);
    chk({tag, "_busy_cycles"}, busy_n, exp_n + 1);
    tick;
    chk({tag, "_idle_after"}, {30'd0, dbg_state}, ST_IDLE);
  endtask

  initial begin
    int a0, a1, acks;
    logic got;
    R = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
    OP0 = OP_NOP; OP1 = OP_NOP; ARG0 = '0; ARG1 = '0; FILL0 = 1'b0; FILL1 = 1'b0;
    tick; tick;

    chk("reset_state", {30'd0, dbg_state}, ST_IDLE);
    chk("reset_busy", BUSY, 0);
    chk("reset_strobes", strobes(), 0);
    chk("reset_acks", {ACK0, ACK1}, 0);
    chk("reset_d", D, 0);
    chk("reset_w", W, 4'hF);
    R = 1'b0;
    tick;

    // LOAD 10 from requester 0, cycle by cycle
    set_req(0, OP_LOAD, 4'd10, 1'b0);
    tick;
    chk("load_strobes", strobes(), 6'b100000);
    chk("load_d", D, 10);
    chk("load_busy_run", BUSY, 1);
    chk("load_ack_early", ACK0, 0);
    tick;
    chk("load_ack0", ACK0, 1);
    chk("load_strobes_done", strobes(), 0);
    chk("load_busy_done", BUSY, 1);
    drop(0);
    tick;
    chk("load_idle_busy", BUSY, 0);
    chk("load_idle_ack", ACK0, 0);

    do_cmd("inc3", 1, OP_INC, 4'd3, 1'b0, 6'b010000, 3, 4'd0);
    do_cmd("inc0", 1, OP_INC, 4'd0, 1'b0, 6'b010000, 1, 4'd0);

    // Simultaneous DEC requests after reset: requester 0 first
    do_reset;
    set_req(0, OP_DEC, 4'd1, 1'b0);
    set_req(1, OP_DEC, 4'd1, 1'b0);
    a0 = -1; a1 = -1;
    for (int c = 1; c <= 20 && a1 < 0; c++) begin
      tick;
      if (ACK0 && a0 < 0) begin a0 = c; drop(0); end
      if (ACK1 && a1 < 0) begin a1 = c; drop(1); end
    end
    chk("tie_ack0_cycle", a0, 2);
    chk("tie_ack1_cycle", a1, 5);
    chk("tie_gap", a1 - a0, 3);
    tick;

    // WSET then shifts
    set_req(0, OP_WSET, 4'd7, 1'b0);
    tick;
    chk("wset_w", W, 7);
    chk("wset_ack0", ACK0, 1);
    chk("wset_strobes", strobes(), 0);
    chk("wset_state", {30'd0, dbg_state}, ST_DONE);
    drop(0);
    tick;
    chk("wset_idle", BUSY, 0);
    chk("wset_w_hold", W, 7);
    do_cmd("shr2", 0, OP_SHR, 4'd2, 1'b1, 6'b000010, 2, 4'hF);
    do_cmd("shl_fill0", 1, OP_SHL, 4'd1, 1'b0, 6'b000100, 1, 4'h0);
    do_cmd("clr", 0, OP_CLR, 4'd9, 1'b0, 6'b000001, 1, 4'h0);
    do_cmd("nop", 1, OP_NOP, 4'd5, 1'b0, 6'b000000, 0, 4'h0);
    chk("w_held", W, 7);

    // Reset in the 2nd RUN cycle of INC x5 aborts without ACK
    set_req(1, OP_INC, 4'd5, 1'b0);
    tick; tick;
    chk("abort_pre_inc", INC, 1);
    #2 R = 1'b1;
    #1;
    chk("abort_strobes", strobes(), 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_state", {30'd0, dbg_state}, ST_IDLE);
    chk("abort_w", W, 4'hF);
    chk("abort_acks", {ACK0, ACK1}, 0);
    drop(1);
    tick; tick;
    R = 1'b0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (ACK0 || ACK1 || BUSY) acks++;
    end
    chk("abort_quiet", acks, 0);

    // Both held continuously: grants alternate 0,1,0,1
    do_reset;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    set_req(0, OP_LOAD, 4'd3, 1'b0);
    set_req(1, OP_INC, 4'd1, 1'b0);
    acks = 0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      tick;
      if (ACK0 && ACK1) chk("alt_both_ack", 1, 0);
      if (ACK0 || ACK1) begin
        got = ACK1;
        acks++;
        if (exp_q.size() > 0) chk("alt_order", got, exp_q.pop_front());
      end
    end
    chk("alt_ack_count", acks, 4);
    drop(0); drop(1);
    tick; tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
